// File: rtl/avalon_onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM slave: byte-enabled writes, pipelined reads of latency 1 or 2,
// post-reset zero clear, and SLVERR on out-of-range reads. Optional macro: ONCHIP_RAM_PARITY_EN.
module avalon_onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int DEPTH          = 10240,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic [1:0]              response,
`ifdef ONCHIP_RAM_PARITY_EN
  output logic                    parity_err,
`endif
  output logic                    init_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [IDX_W-1:0]        clr_cnt_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic                    stall_s;
  logic                    in_range_s;
  logic                    accept_s;
  logic                    wr_en_s;
  logic                    rd_en_s;
  logic                    clr_en_s;
  logic [IDX_W-1:0]        idx_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;
  logic                    rd_err_s;
  logic [1:0]              rd_resp_s;

  logic                    s1_valid_r;
  logic [DATA_WIDTH-1:0]   s1_data_r;
  logic [1:0]              s1_resp_r;
  logic                    out_valid_r;

  assign stall_s     = ~clken | reset_req;
  assign waitrequest = reset | stall_s | (state_r != READY);
  assign in_range_s  = ({1'b0, address} < DEPTH_W);
  assign idx_s       = address[IDX_W-1:0];
  assign accept_s    = chipselect & (read | write) & ~waitrequest;
  // A simultaneous read+write is a write; out-of-range writes vanish here.
  assign wr_en_s     = accept_s & write & in_range_s;
  assign rd_en_s     = accept_s & ~write;
  assign clr_en_s    = (state_r == CLEAR) & ~reset & ~stall_s & (CLEAR_ON_RESET != 0);
  assign rd_word_s   = mem_r[idx_s];
  assign rd_data_s   = in_range_s ? rd_word_s : {DATA_WIDTH{1'b0}};
  assign rd_resp_s   = rd_err_s ? RESP_SLVERR : RESP_OKAY;
  assign readdatavalid = out_valid_r & ~stall_s & ~reset;

`ifdef ONCHIP_RAM_PARITY_EN
  logic [NB-1:0] par_r [DEPTH];
  logic          par_mismatch_s;

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  assign par_mismatch_s = in_range_s & (byte_parity(rd_word_s) != par_r[idx_s]);
  assign rd_err_s       = ~in_range_s | par_mismatch_s;

  // Parity storage follows the data array byte for byte.
  always_ff @(posedge clk) begin
    if (clr_en_s) begin
      par_r[clr_cnt_r] <= {NB{1'b0}};
    end else if (wr_en_s) begin
      for (int b = 0; b < NB; b++)
        if (byteenable[b]) par_r[idx_s][b] <= ^writedata[8*b +: 8];
    end
  end

  // Sticky parity error flag.
  always_ff @(posedge clk) begin
    if (reset) parity_err <= 1'b0;
    else if (rd_en_s & par_mismatch_s) parity_err <= 1'b1;
  end
`else
  assign rd_err_s = ~in_range_s;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= CLEAR;
    else       state_r <= state_next_s;
  end

  // Next state: CLEAR finishes after the last address is zeroed, or at once when clearing is off.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CLEAR: begin
        if (CLEAR_ON_RESET == 0)                  state_next_s = READY;
        else if (clr_en_s && clr_cnt_r == LAST_IDX) state_next_s = READY;
        else                                      state_next_s = CLEAR;
      end
      READY:   state_next_s = READY;
      default: state_next_s = CLEAR;
    endcase
  end

  // Clear counter and init_done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt_r <= {IDX_W{1'b0}};
      init_done <= 1'b0;
    end else begin
      if (clr_en_s) clr_cnt_r <= clr_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
      init_done <= (state_next_s == READY);
    end
  end

  // RAM write port shared by the clear sequencer and the bus.
  always_ff @(posedge clk) begin
    if (clr_en_s) begin
      mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr_en_s) begin
      for (int b = 0; b < NB; b++)
        if (byteenable[b]) mem_r[idx_s][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  // Read pipeline: advances only on non-stalled cycles; readdata holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r  <= 1'b0;
      s1_data_r   <= {DATA_WIDTH{1'b0}};
      s1_resp_r   <= RESP_OKAY;
      out_valid_r <= 1'b0;
      readdata    <= {DATA_WIDTH{1'b0}};
      response    <= RESP_OKAY;
    end else if (!stall_s) begin
      if (READ_LATENCY == 2) begin
        s1_valid_r  <= rd_en_s;
        if (rd_en_s) begin
          s1_data_r <= rd_data_s;
          s1_resp_r <= rd_resp_s;
        end
        out_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          readdata  <= s1_data_r;
          response  <= s1_resp_r;
        end
      end else begin
        out_valid_r <= rd_en_s;
        if (rd_en_s) begin
          readdata  <= rd_data_s;
          response  <= rd_resp_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_onchip_ram_pipelined.sv
// Randomized bench: two RAM instances (read latency 1 and 2, DEPTH=16) share stimulus and are
// compared each cycle against a transaction-level model of memory, clear progress and read returns.
module tb_avalon_onchip_ram_pipelined;
  localparam int DEP = 16;
  localparam int AW  = 5;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          rem;
  } pend_t;

  logic        clk = 1'b0;
  logic        reset, chipselect, read, write, clken, reset_req;
  logic [AW-1:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;

  logic [31:0] rdata [2];
  logic        rdv [2];
  logic        waitreq [2];
  logic [1:0]  resp [2];
  logic        initd [2];
`ifdef ONCHIP_RAM_PARITY_EN
  logic        perr [2];
`endif

  logic [31:0] ref_mem [DEP];
  bit          ready;
  int          clear_left;
  pend_t       pq [2][$];
  int          check_count = 0;
  int          fail_count = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    avalon_onchip_ram_pipelined #(
      .DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(g + 1), .CLEAR_ON_RESET(1)
    ) u_dut (
      .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .readdata(rdata[g]), .readdatavalid(rdv[g]),
      .waitrequest(waitreq[g]), .response(resp[g]),
`ifdef ONCHIP_RAM_PARITY_EN
      .parity_err(perr[g]),
`endif
      .init_done(initd[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic compare();
    bit stall, exp_wait, exp_v;
    stall    = !clken || reset_req;
    exp_wait = reset || stall || !ready;
    for (int k = 0; k < 2; k++) begin
      exp_v = !reset && !stall && pq[k].size() > 0 && pq[k][0].rem == 0;
      check($sformatf("waitrequest_L%0d", k + 1), {31'b0, waitreq[k]}, {31'b0, exp_wait});
      check($sformatf("init_done_L%0d", k + 1), {31'b0, initd[k]}, {31'b0, ready});
      check($sformatf("readdatavalid_L%0d", k + 1), {31'b0, rdv[k]}, {31'b0, exp_v});
      if (exp_v) begin
        check($sformatf("readdata_L%0d", k + 1), rdata[k], pq[k][0].data);
        check($sformatf("response_L%0d", k + 1), {30'b0, resp[k]}, {30'b0, pq[k][0].resp});
      end
`ifdef ONCHIP_RAM_PARITY_EN
      if (!reset) check($sformatf("parity_err_L%0d", k + 1), {31'b0, perr[k]}, 32'd0);
`endif
    end
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_update();
    bit    stall, acc;
    pend_t e;
    stall = !clken || reset_req;
    acc   = ready && !stall && !reset && chipselect && (read || write);
    if (reset) begin
      ready = 1'b0;
      clear_left = DEP;
      pq[0].delete();
      pq[1].delete();
    end else begin
      if (!stall) begin
        for (int k = 0; k < 2; k++) begin
          if (pq[k].size() > 0 && pq[k][0].rem == 0) void'(pq[k].pop_front());
          for (int i = 0; i < pq[k].size(); i++) begin
            e = pq[k][i];
            e.rem = e.rem - 1;
            pq[k][i] = e;
          end
          if (acc && !write) begin
            e.data = (address < DEP) ? ref_mem[address[3:0]] : 32'd0;
            e.resp = (address < DEP) ? 2'b00 : 2'b10;
            e.rem  = k;
            pq[k].push_back(e);
          end
        end
      end
      if (!ready) begin
        if (!stall) begin
          clear_left--;
          if (clear_left == 0) begin
            ready = 1'b1;
            for (int i = 0; i < DEP; i++) ref_mem[i] = 32'd0;
          end
        end
      end else if (acc && write && address < DEP) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) ref_mem[address[3:0]][8*b +: 8] = writedata[8*b +: 8];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cycle(input bit rst, input bit cs, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d,
                          input bit ce, input bit rr);
    reset = rst; chipselect = cs; read = rd; write = wr; address = a;
    byteenable = be; writedata = d; clken = ce; reset_req = rr;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    ready = 1'b0;
    clear_left = DEP;
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("reset_readdata", rdata[k], 32'd0);
      check("reset_response", {30'b0, resp[k]}, 32'd0);
    end
    idle(17);

    // Byte-enable merge, then out-of-range traffic and back-to-back reads.
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 4'h5, 32'h11223344, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 4'h0, 32'd0, 1'b1, 1'b0);
    idle(1);
    check("merge_L1", rdata[0], 32'hDE22BE44);
    check("merge_L2", rdata[1], 32'hDE22BE44);
    idle(1);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 4'hF, 32'hA1A1A1A1, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 4'hF, 32'hB2B2B2B2, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 4'hF, 32'hC3C3C3C3, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd16, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd16, 4'h0, 32'd0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 4'h0, 32'd0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 4'h0, 32'd0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 4'h0, 32'd0, 1'b1, 1'b0);
    // Write then read same address, and read then write same address.
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h0BADF00D, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 4'h0, 32'd0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h12345678, 1'b1, 1'b0);
    idle(3);

    // Stall right after a read is accepted.
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 4'h0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 4'h0, 32'd0, 1'b0, 1'b0);
    idle(3);

    // In-flight read dropped by reset, then a clear interrupted at step 7.
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 4'h0, 32'd0, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 1'b0);
    idle(7);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 1'b0);
    idle(18);

    for (int n = 0; n < 3000; n++) begin
      do_cycle($urandom_range(0, 249) == 0,
               $urandom_range(0, 7) != 0,
               1'($urandom),
               1'($urandom),
               ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15)),
               4'($urandom),
               $urandom,
               $urandom_range(0, 9) != 0,
               $urandom_range(0, 19) == 0);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end
endmodule

// File: doc/avalon_onchip_ram_pipelined.md
Name: avalon_onchip_ram_pipelined

Overview:
- Parametrised Avalon-MM on-chip RAM slave; successor to the fixed 32-bit x 10240-word single-port on-chip memory.
- Adds configurable width, depth and read latency, plus readdatavalid and waitrequest handshaking.
- Adds an error response for out-of-range addresses and a post-reset zero-clear sequencer.
- Sits on the system interconnect as the processor's program/data memory; read pipelining is handled by the slave itself.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 14, word address width.
- DEPTH, 10240, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, when 1 the whole array is written to zero after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  word address.
- byteenable  in  DATA_WIDTH/8  per-byte write enables.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_WIDTH  write data.
- clken  in  1  clock enable; 0 stalls the block.
- reset_req  in  1  pending-reset hint; 1 stalls the block.
- readdata  out  DATA_WIDTH  read data, valid only while readdatavalid=1.
- readdatavalid  out  1  read-data strobe.
- waitrequest  out  1  command back-pressure.
- response  out  2  00 = OKAY, 10 = SLVERR; qualified by readdatavalid.
- init_done  out  1  high once the clear sequence has finished.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: readdata=0, readdatavalid=0, response=00, init_done=0, waitrequest=1. The read pipeline is flushed; in-flight reads are discarded and never return.
- Stall condition: stall = ~clken | reset_req.
  - During a stall, waitrequest=1 and no command is accepted.
  - The read pipeline holds its state and readdatavalid is forced to 0.
  - The held data is presented on the first non-stalled cycle.
- FSM has two states, CLEAR and READY.
  - CLEAR, entered from reset: a counter writes 0 to addresses 0..DEPTH-1, one per non-stalled cycle. waitrequest=1 throughout. After address DEPTH-1 is written, go to READY and set init_done=1.
  - With CLEAR_ON_RESET=0, CLEAR lasts exactly one cycle and performs no writes; RAM contents are undefined.
  - Reset asserted in any state returns the FSM to CLEAR with the counter at 0. A clear interrupted by reset restarts from 0.
  - READY: waitrequest = stall. The FSM stays in READY until reset.
- A command is accepted when chipselect & (read | write) & ~waitrequest.
- Write: writes only the bytes whose byteenable bit is 1.
  - byteenable all-zero: no change, no error.
  - No readdatavalid is generated for writes.
- Read: readdatavalid pulses exactly READ_LATENCY non-stalled cycles after acceptance.
  - Fully pipelined: one read may be accepted per cycle, and readdatavalid may stay high on consecutive cycles.
  - Data returns in issue order.
- read and write both asserted: treated as a write only; the read is ignored.
- Out-of-range address (address >= DEPTH):
  - Write: dropped, with no side effect.
  - Read: returns readdata=0 with response=10 at the normal latency.
  - In-range reads return response=00.
- Write to address A followed by a read of A on the next cycle: the read returns the newly written data (no stale-read hazard).
- Back-to-back read at cycle N and write at N+1 to the same address: the read returns the old data.
- readdata is registered and holds its last value while readdatavalid=0. Masters must not sample it then.

Optional Feature:
- Macro: ONCHIP_RAM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte and written alongside that byte's data.
  - Every in-range read checks parity. A mismatch returns response=10 with the data as stored.
  - Extra output parity_err (1 bit) is a sticky flag, set on any mismatch and cleared only by reset.
  - The clear sequence writes a parity bit of 0 for zero data.
- When not defined: no parity storage, no parity_err port, and in-range reads always return response=00.

Test Plan:
- Reset then clear, DEPTH=16, CLEAR_ON_RESET=1: waitrequest=1 for 16 cycles; init_done rises on cycle 17; reading every address returns 0 with response=00.
- Write 0xDEADBEEF to address 5 with byteenable=0xF, then write 0x11223344 to address 5 with byteenable=0x5: a read of address 5 returns 0xDE22BE44, with readdatavalid exactly 1 cycle after acceptance (READ_LATENCY=1).
- READ_LATENCY=2, reads of addresses 1, 2, 3 on consecutive cycles: readdatavalid is high for 3 consecutive cycles starting 2 cycles after the first read, with data in order 1, 2, 3.
- Stall: clken=0 for 3 cycles immediately after a read is accepted: waitrequest=1 and readdatavalid=0 during the stall; readdatavalid=1 with the correct data on the first cycle after clken returns to 1.
- Out-of-range, DEPTH=10240: writing 0xFFFFFFFF to address 10240 changes nothing; a read of 10240 returns readdata=0 with response=10; a read of address 0 is unaffected.
- Reset asserted at clear step 7: the FSM restarts in CLEAR; init_done rises only after a full DEPTH-cycle clear; the in-flight read is dropped with no readdatavalid.
